// File: rtl/shift_reg_pkg.sv
// Shared definitions for the parameterised shift register:
// mode encoding and fill-counter width helper.
package shift_reg_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'b00,
        SHR  = 2'b01,
        SHL  = 2'b10,
        LOAD = 2'b11
    } mode_e;

    // Fill counter width; never narrower than one bit.
    function automatic int cw_f(input int stages);
        return (stages < 2) ? 1 : $clog2(stages);
    endfunction

endpackage

// File: rtl/shift_fill_ctr.sv
// Word fill counter with registered frame_done pulse.
// Ports: clk, rst_n (async low), clear_i, load_i, step_i in;
//        fill_cnt_o (words in frame), frame_done_o (1-cycle pulse) out.
module shift_fill_ctr
    import shift_reg_pkg::*;
#(
    parameter  int STAGES = 2,
    localparam int CW     = cw_f(STAGES)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear_i,
    input  logic          load_i,
    input  logic          step_i,
    output logic [CW-1:0] fill_cnt_o,
    output logic          frame_done_o
);

    localparam logic [CW-1:0] LAST = CW'(STAGES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;

    always_comb begin
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (clear_i || load_i) begin
            cnt_d = '0;
        end else if (step_i) begin
            // Last word wraps the count; a step while done is high
            // therefore becomes word 0 of the next frame.
            if (cnt_q == LAST) begin
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign fill_cnt_o   = cnt_q;
    assign frame_done_o = done_q;

endmodule

// File: rtl/param_shift_reg.sv
// Parameterised word shift register: hold, shift right/left, load.
// Ports: clk, rst_n (async low), clear, mode[1:0], rotate, data_in,
//        load_data in; data_out, fill_cnt, frame_done out.
// Build option: define SHREG_ROTATE_EN to make rotate active.
module param_shift_reg
    import shift_reg_pkg::*;
#(
    parameter  int DIN_W  = 4,
    parameter  int STAGES = 2,
    localparam int TW     = DIN_W * STAGES,
    localparam int CW     = cw_f(STAGES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [1:0]       mode,
    input  logic             rotate,
    input  logic [DIN_W-1:0] data_in,
    input  logic [TW-1:0]    load_data,
    output logic [TW-1:0]    data_out,
    output logic [CW-1:0]    fill_cnt,
    output logic             frame_done
);

    logic [TW-1:0] reg_q, reg_d;
    logic          step;
    logic          rot_en;
    mode_e         mode_s;

    assign mode_s = mode_e'(mode);

`ifdef SHREG_ROTATE_EN
    assign rot_en = rotate;
`else
    logic unused_rotate;
    assign unused_rotate = rotate;
    assign rot_en        = 1'b0;
`endif

    always_comb begin
        reg_d = reg_q;
        step  = 1'b0;
        unique case (mode_s)
            HOLD: begin
                reg_d = reg_q;
            end
            SHR: begin
                step  = 1'b1;
                reg_d = rot_en ? {reg_q[DIN_W-1:0], reg_q[TW-1:DIN_W]}
                               : {data_in, reg_q[TW-1:DIN_W]};
            end
            SHL: begin
                step  = 1'b1;
                reg_d = rot_en ? {reg_q[TW-DIN_W-1:0], reg_q[TW-1:TW-DIN_W]}
                               : {reg_q[TW-DIN_W-1:0], data_in};
            end
            LOAD: begin
                reg_d = load_data;
            end
            default: begin
                reg_d = reg_q;
            end
        endcase
        if (clear) begin
            reg_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_q <= '0;
        end else begin
            reg_q <= reg_d;
        end
    end

    assign data_out = reg_q;

    shift_fill_ctr #(
        .STAGES (STAGES)
    ) u_fill_ctr (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (clear),
        .load_i       (mode_s == LOAD),
        .step_i       (step),
        .fill_cnt_o   (fill_cnt),
        .frame_done_o (frame_done)
    );

endmodule
